mem_responder: RTL
==================

# mem_responder

Memory-side responder for the datapath's MAR/MDR memory interface. It accepts read and write requests from the CPU control unit, holds the address and write data, inserts a configurable number of wait states, and then either commits the write to an internal word array or returns the read word on `Mdatain`. A four-phase handshake, with `mem_done` held until the request drops, lets the control sequencer stall on memory. It sits between MAR/MDR and the control unit in place of the behavioural memory chip.

## Interface
- `DATA_WIDTH`, 32, word width of stored data, `MDRout` and `Mdatain`
- `ADDR_WIDTH`, 9, address width; array depth is 2**ADDR_WIDTH words, so no address is out of range
- `WAIT_CYCLES`, 2, wait states inserted before the access; legal range 0..15
- `INIT`, 32'h00000000, power-up value of every array word and of `Mdatain`

- `clock`  in  1  single clock; all state changes on the rising edge
- `clear`  in  1  reset, synchronous and active-high
- `read`  in  1  read request level, from the control unit
- `write`  in  1  write request level, from the control unit
- `MARout`  in  ADDR_WIDTH  word address, from MAR
- `MDRout`  in  DATA_WIDTH  write data, from MDR
- `Mdatain`  out  DATA_WIDTH  read data to MDR's memory input; registered
- `mem_done`  out  1  access complete; held until the request drops
- `busy`  out  1  high in WAIT, ACCESS and DONE
- `err`  out  1  one-cycle pulse when `read` and `write` are both high in IDLE

## Operation
- States: IDLE, WAIT, ACCESS, DONE.
- IDLE, exactly one of `read`/`write` high:
  - latch `MARout`, `MDRout` and the op type
  - load wait counter with WAIT_CYCLES
  - go to WAIT, or to ACCESS if WAIT_CYCLES = 0
- IDLE, `read` and `write` both high:
  - `err` = 1 for one cycle
  - no latch, no access; stay IDLE
- WAIT:
  - counter decrements each cycle; go to ACCESS when the counter reaches 1
  - `read`, `write`, `MARout` and `MDRout` are ignored; latched values are used
- ACCESS (one cycle):
  - write: array[addr] <= data
  - read: `Mdatain` <= array[addr]
  - go to DONE
- DONE:
  - `mem_done` = 1
  - return to IDLE on the first edge where `read` = 0 and `write` = 0
  - if a request is still high, stay in DONE; no new access starts
- `Mdatain` changes only in ACCESS of a read or on `clear`. Writes never disturb it.
- `clear` in any state:
  - next state IDLE; `Mdatain` = 0, `mem_done` = 0, `busy` = 0, `err` = 0
  - the array is not cleared
  - a write aborted before ACCESS is never committed; a write whose ACCESS edge coincides with `clear` is not committed either (`clear` has priority)

## Timing
- Reset values: `Mdatain` 0, `mem_done` 0, `busy` 0, `err` 0, state IDLE.
- Request sampled in IDLE at edge N:
  - `busy` is high after edge N
  - the access occurs at edge N+W+1, where W = WAIT_CYCLES
  - `mem_done` and read data are valid after edge N+W+1, so latency is W+1 cycles
- Release: the request is low at edge M, so `mem_done` and `busy` are low after edge M.
- The earliest next request is sampled at edge M+1. The minimum read-to-read period is W+3 cycles.
- `err` is high for exactly the cycle after the sampling edge.
- An op switch such as read to write without dropping both lines first stays in DONE until both are low.

## Test plan
- Reset: assert `clear` for 2 cycles -> all outputs 0, `busy` 0; then write 32'hDEADBEEF to address 0x05 with W=2 -> `mem_done` rises 3 cycles after the request is sampled.
- Read back 0x05 with W=2 -> `Mdatain` = 32'hDEADBEEF with `mem_done`; `mem_done` stays high while `read` is held 4 extra cycles and falls one cycle after `read` drops.
- Back-to-back: write 0x1 -> 0x10, write 0xA5A5A5A5 -> 0x1FF, read 0x10, read 0x1FF -> data 0x1, 0xA5A5A5A5; the read-to-read period is 5 cycles.
- `read` and `write` both asserted in IDLE -> `err` pulses 1 cycle, `busy` stays 0, array unchanged, `Mdatain` unchanged.
- `clear` during WAIT of a write of 0x12345678 to 0x20 (old value 0x0) -> outputs reset, and a later read of 0x20 returns 0x0.
- WAIT_CYCLES = 0 -> `mem_done` is valid one cycle after the sampling edge; `MARout` changed during DONE does not alter `Mdatain`.

Source files
------------

// File: rtl/mem_responder_if.sv
// mem_responder_if: MAR/MDR request/response bus between the control unit and the memory responder
interface mem_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
);
  logic                  read;
  logic                  write;
  logic [ADDR_WIDTH-1:0] MARout;
  logic [DATA_WIDTH-1:0] MDRout;
  logic [DATA_WIDTH-1:0] Mdatain;
  logic                  mem_done;
  logic                  busy;
  logic                  err;
  modport master (output read, write, MARout, MDRout, input Mdatain, mem_done, busy, err);
  modport slave  (input read, write, MARout, MDRout, output Mdatain, mem_done, busy, err);
endinterface

// File: rtl/mem_responder.sv
// mem_responder: wait-stated word memory with a four-phase read/write handshake
module mem_responder #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 9,
  parameter int                    WAIT_CYCLES = 2,
  parameter logic [DATA_WIDTH-1:0] INIT        = '0
) (
  input logic             clock,
  input logic             clear,
  mem_responder_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;
  state_t                state, next;
  logic                  start;
  logic                  op_wr;
  logic                  err_q;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata = INIT;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH] = '{default: INIT};
  always_ff @(posedge clock) state <= clear ? IDLE : next;
  always_comb begin
    start = state == IDLE && (bus.read ^ bus.write);
    next  = state;
    case (state)
      IDLE:    next = start ? (WAIT_CYCLES == 0 ? ACCESS : WAIT) : IDLE;
      WAIT:    next = cnt == 4'd1 ? ACCESS : WAIT;
      ACCESS:  next = DONE;
      DONE:    next = !bus.read && !bus.write ? IDLE : DONE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (clear) begin
      rdata <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= state == IDLE && bus.read && bus.write;
      if (start) begin
        addr  <= bus.MARout;
        wdata <= bus.MDRout;
        op_wr <= bus.write;
        cnt   <= 4'(WAIT_CYCLES);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (state == ACCESS && !op_wr) rdata <= mem[addr];
    end
  end
  // clear wins over a write whose ACCESS edge coincides with it
  always_ff @(posedge clock)
    if (!clear && state == ACCESS && op_wr) mem[addr] <= wdata;
  assign bus.Mdatain  = rdata;
  assign bus.mem_done = state == DONE;
  assign bus.busy     = state != IDLE;
  assign bus.err      = err_q;
endmodule
